// File: rtl/obi_mem_arbiter.sv
// Two-master (insn = 0, data = 1) to one-slave OBI arbiter with an in-order ID FIFO for response routing.
// Define OBI_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise master 1 has fixed priority.
module obi_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [1:0]       m_req_i,
    output logic [1:0]       m_gnt_o,
    input  logic [1:0][31:0] m_addr_i,
    input  logic [1:0]       m_we_i,
    input  logic [1:0][3:0]  m_be_i,
    input  logic [1:0][31:0] m_wdata_i,
    output logic [1:0]       m_rvalid_o,
    input  logic [1:0]       m_rready_i,
    output logic [1:0][31:0] m_rdata_o,
    output logic             s_req_o,
    input  logic             s_gnt_i,
    output logic [31:0]      s_addr_o,
    output logic             s_we_o,
    output logic [3:0]       s_be_o,
    output logic [31:0]      s_wdata_o,
    input  logic             s_rvalid_i,
    output logic             s_rready_o,
    input  logic [31:0]      s_rdata_i
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [CW-1:0]              cnt;
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [MAX_OUTSTANDING-1:0] id_fifo;
    logic                       lock;
    logic                       lock_id;
    logic                       winner;
    logic                       blocked;
    logic                       fifo_empty;
    logic                       head;
    logic                       push;
    logic                       pop;
`ifdef OBI_ARB_ROUND_ROBIN_EN
    logic                       rr_last;
`endif

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(MAX_OUTSTANDING - 1)) n = '0;
        else                               n = p + 1'b1;
        return n;
    endfunction

    // Blocking uses the registered count only, so a same-cycle pop never unblocks.
    assign blocked    = (cnt == CW'(MAX_OUTSTANDING));
    assign fifo_empty = (cnt == '0);
    assign head       = id_fifo[rd_ptr];

    always_comb begin
        winner = m_req_i[1];
        if (lock) begin
            winner = lock_id;
        end else if (&m_req_i) begin
`ifdef OBI_ARB_ROUND_ROBIN_EN
            winner = ~rr_last;
`else
            winner = 1'b1;
`endif
        end
    end

    assign s_req_o   = rst_n_i & ~blocked & (|m_req_i);
    assign s_addr_o  = m_addr_i[winner];
    assign s_we_o    = m_we_i[winner];
    assign s_be_o    = m_be_i[winner];
    assign s_wdata_o = m_wdata_i[winner];

    always_comb begin
        m_gnt_o         = '0;
        m_gnt_o[winner] = s_req_o & s_gnt_i;
    end

    // With nothing outstanding, stray responses are drained and not forwarded.
    assign s_rready_o = fifo_empty ? 1'b1 : m_rready_i[head];

    always_comb begin
        m_rvalid_o = '0;
        if (rst_n_i && !fifo_empty) m_rvalid_o[head] = s_rvalid_i;
    end

    assign m_rdata_o = {s_rdata_i, s_rdata_i};

    assign push = s_req_o & s_gnt_i;
    assign pop  = s_rvalid_i & s_rready_o & ~fifo_empty;

    always_ff @(posedge clk_i) begin
        if (push) id_fifo[wr_ptr] <= winner;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lock    <= 1'b0;
            lock_id <= 1'b0;
`ifdef OBI_ARB_ROUND_ROBIN_EN
            rr_last <= 1'b1;
`endif
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (s_req_o) begin
                lock    <= ~s_gnt_i;
                lock_id <= winner;
            end
`ifdef OBI_ARB_ROUND_ROBIN_EN
            if (push) rr_last <= winner;
`endif
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            assert (!(s_rvalid_i && fifo_empty))
                else $warning("obi_mem_arbiter: slave response with no outstanding transaction");
        end
    end
`endif

endmodule

// File: doc/obi_mem_arbiter.md
# obi_mem_arbiter

Two-master to one-slave OBI arbiter that lets the core's instruction-fetch port (master 0) and data port (master 1) share a single unified memory. It sits between the core's memory-side interfaces and the memory or bus slave. It selects the address-phase winner and locks that choice until the slave grants it. It records the master ID of every granted transaction in an in-order ID FIFO so each response phase is routed back to the master that issued it.

## Interface
Parameters:
- MAX_OUTSTANDING, default 2: maximum granted-but-unanswered transactions; ID FIFO depth; legal range 1..8.

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_n_i  in  1  reset; synchronous, active-low.
- m_req_i  in  [1:0]  per-master request; bit 0 is insn, bit 1 is data.
- m_gnt_o  out  [1:0]  per-master grant.
- m_addr_i  in  [1:0][31:0]  per-master address.
- m_we_i  in  [1:0]  per-master write enable.
- m_be_i  in  [1:0][3:0]  per-master byte enables.
- m_wdata_i  in  [1:0][31:0]  per-master write data.
- m_rvalid_o  out  [1:0]  per-master response valid.
- m_rready_i  in  [1:0]  per-master response ready.
- m_rdata_o  out  [1:0][31:0]  per-master read data; both entries carry s_rdata_i.
- s_req_o / s_gnt_i / s_addr_o / s_we_o / s_be_o / s_wdata_o / s_rvalid_i / s_rready_o / s_rdata_i  (out/in/out/out/out/out/in/out/in)  1/1/32/1/4/32/1/1/32  slave-side OBI channel.

## Operation
- **Blocking.** The arbiter is blocked when cnt == MAX_OUTSTANDING. A pop in the same cycle does not unblock it. While blocked, s_req_o = 0 and m_gnt_o = 0.
- **Selection, unlocked.**
  - The winner is chosen among masters with m_req_i set.
  - Fixed priority by default: master 1 beats master 0.
  - s_req_o = |m_req_i. Address-phase signals (addr, we, be, wdata) are muxed from the winner.
  - m_gnt_o[winner] = s_gnt_i; the loser's grant is 0.
- **Lock.** When s_req_o && !s_gnt_i, the registers lock = 1 and lock_id = winner are set.
  - While locked, the selection is lock_id regardless of the other master's request. This keeps address-phase signals stable as OBI requires.
  - lock clears on the cycle s_gnt_i = 1.
- **Grant handshake.** s_req_o && s_gnt_i pushes the winner ID into the FIFO and increments cnt.
- **Response routing.**
  - head = FIFO front ID.
  - m_rvalid_o[head] = s_rvalid_i, and 0 for the other master.
  - s_rready_o = m_rready_i[head].
  - s_rvalid_i && s_rready_o pops the FIFO and decrements cnt.
- **Simultaneous push and pop** in one cycle: cnt is unchanged and the FIFO pointers both advance.
- **Empty FIFO.** s_rvalid_i with an empty FIFO is a slave protocol violation.
  - No m_rvalid_o is raised, there is no pop, and s_rready_o = 1 (drain).
  - A simulation-only assertion flags it.
- **Widths.**
  - cnt is $clog2(MAX_OUTSTANDING+1) bits; it never exceeds MAX_OUTSTANDING and never underflows.
  - FIFO pointers are $clog2(MAX_OUTSTANDING) bits, minimum 1, and wrap modulo MAX_OUTSTANDING.
- **Reset.**
  - rst_n_i low for one rising edge clears cnt, both FIFO pointers, lock, lock_id = 0 and rr_last = 1.
  - While rst_n_i is low, s_req_o, m_gnt_o and m_rvalid_o are forced to 0 combinationally.
  - In-flight transactions are dropped. Late responses then hit the empty-FIFO rule.

## Timing
- **Zero-latency combinational paths:**
  - m_req_i → s_req_o.
  - s_gnt_i → m_gnt_o.
  - s_rvalid_i → m_rvalid_o.
  - m_rready_i → s_rready_o.
- No path from s_rvalid_i to s_req_o or m_gnt_o: blocking uses registered cnt only.
- A push is visible at the FIFO head the cycle after the grant. A response in the grant cycle of the first transaction is therefore treated as empty-FIFO. OBI slaves respond no earlier than the cycle after gnt.
- Back-to-back grants are sustained at one per cycle until cnt reaches MAX_OUTSTANDING.
- One response per cycle maximum. Responses return in grant order.

## Configuration
- Macro: OBI_ARB_ROUND_ROBIN_EN.
- **Defined:** round-robin arbitration.
  - Register rr_last holds the last granted ID. On contention the master ≠ rr_last wins.
  - rr_last updates on each grant handshake and resets to 1, so master 0 wins the first contention.
  - Lock behaviour is unchanged.
- **Undefined:** fixed priority, master 1 over master 0. rr_last is not implemented.

## Test plan
- **Single fetch.** Reset, then m_req_i = 01 with addr 0x100, s_gnt_i = 1 → s_addr_o = 0x100 and m_gnt_o = 01 in the same cycle. Next cycle s_rvalid_i = 1 with rdata 0xDEADBEEF → m_rvalid_o = 01, m_rdata_o[0] = 0xDEADBEEF, cnt returns to 0.
- **Contention.** m_req_i = 11 with s_gnt_i = 1 for 2 cycles, default build → grants go 10, then 10 while data still requests. With OBI_ARB_ROUND_ROBIN_EN → grants go 01, then 10.
- **Lock.** Insn requests alone with s_gnt_i = 0 for 3 cycles, and data raises req in cycle 2 → s_addr_o stays the insn address and m_gnt_o stays 00 until s_gnt_i = 1. The grant goes to 01, and data is served in the next cycle.
- **Full / ordering.** MAX_OUTSTANDING = 2: grant data (0x200), then insn (0x300), with responses held off → third request sees s_req_o = 0. Responses then route m_rvalid_o = 10 then 01. s_req_o reasserts the cycle after the first pop.
- **Reset mid-flight and spurious response.** Reset with cnt = 2, then s_rvalid_i = 1 → m_rvalid_o = 00, s_rready_o = 1, cnt stays 0, and the assertion fires.
